regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates two write-back requesters (0 = ALU, 1 = load unit) onto a single
// register-file write port. It also keeps a busy scoreboard of destinations
// that have been issued and not yet written back, and uses it to stall issue
// on RAW/WAW hazards.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   iss_valid, iss_rs1/rs2/rd  issue request from decode
//   iss_stall                  issue blocked by hazard (combinational)
//   rN_valid/addr/data         write-back requests, N = 0, 1
//   rN_ready                   write-back grant (combinational)
//   rf_we, rf_vf, rf_a3, rf_wd register-file write port (registered)
//   busy                       pending-destination scoreboard (registered)
module regfile_wb_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_stall,
    input  logic            r0_valid,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW-1:0]   r0_data,
    output logic            r0_ready,
    input  logic            r1_valid,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW-1:0]   r1_data,
    output logic            r1_ready,
    output logic            rf_we,
    output logic            rf_vf,
    output logic [AW-1:0]   rf_a3,
    output logic [DW-1:0]   rf_wd,
    output logic [2**AW-1:0] busy
);

    localparam int unsigned NReg = 2**AW;

    // Last-granted requester; resets to 1 so requester 0 wins first contention.
    logic            last_q, last_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_a3_q, rf_a3_d;
    logic [DW-1:0]   rf_wd_q, rf_wd_d;
    logic [NReg-1:0] busy_q, busy_d;

    logic            xfer0, xfer1, xfer;
    logic [AW-1:0]   xfer_addr;
    logic [DW-1:0]   xfer_data;
    logic            iss_accept;

    // Grant depends only on the two valids and the pointer.
    always_comb begin
        r0_ready = r0_valid & (~r1_valid | last_q);
        r1_ready = r1_valid & (~r0_valid | ~last_q);
    end

    always_comb begin
        xfer0     = r0_valid & r0_ready;
        xfer1     = r1_valid & r1_ready;
        xfer      = xfer0 | xfer1;
        xfer_addr = xfer1 ? r1_addr : r0_addr;
        xfer_data = xfer1 ? r1_data : r0_data;
    end

    // Registered busy only; a clear becomes visible the cycle after commit.
    always_comb begin
        iss_stall  = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
        iss_accept = iss_valid & ~iss_stall;
    end

    always_comb begin
        last_d = last_q;
        if (xfer1) begin
            last_d = 1'b1;
        end else if (xfer0) begin
            last_d = 1'b0;
        end
    end

    // Address 0 transfers are consumed but never reach the register file.
    always_comb begin
        rf_we_d = xfer & (xfer_addr != '0);
        rf_a3_d = rf_a3_q;
        rf_wd_d = rf_wd_q;
        if (rf_we_d) begin
            rf_a3_d = xfer_addr;
            rf_wd_d = xfer_data;
        end
    end

    // Clear on commit first, then set, so a simultaneous set wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_a3_q] = 1'b0;
        end
        if (iss_accept && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q  <= 1'b1;
            rf_we_q <= 1'b0;
            rf_a3_q <= '0;
            rf_wd_q <= '0;
            busy_q  <= '0;
        end else begin
            last_q  <= last_d;
            rf_we_q <= rf_we_d;
            rf_a3_q <= rf_a3_d;
            rf_wd_q <= rf_wd_d;
            busy_q  <= busy_d;
        end
    end

    // Write-valid qualifier tracks the write enable exactly.
    always_comb begin
        rf_we = rf_we_q;
        rf_vf = rf_we_q;
        rf_a3 = rf_a3_q;
        rf_wd = rf_wd_q;
        busy  = busy_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic            clk;
    logic            reset;
    logic            iss_valid;
    logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd;
    logic            iss_stall;
    logic            r0_valid, r1_valid;
    logic [AW-1:0]   r0_addr, r1_addr;
    logic [DW-1:0]   r0_data, r1_data;
    logic            r0_ready, r1_ready;
    logic            rf_we, rf_vf;
    logic [AW-1:0]   rf_a3;
    logic [DW-1:0]   rf_wd;
    logic [31:0]     busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .r0_valid  (r0_valid),
        .r0_addr   (r0_addr),
        .r0_data   (r0_data),
        .r0_ready  (r0_ready),
        .r1_valid  (r1_valid),
        .r1_addr   (r1_addr),
        .r1_data   (r1_data),
        .r1_ready  (r1_ready),
        .rf_we     (rf_we),
        .rf_vf     (rf_vf),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then back to the falling edge where sampling happens.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
        r0_valid = 1'b0; r0_addr = '0; r0_data = '0;
        r1_valid = 1'b0; r1_addr = '0; r1_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        checks++;
        if (rf_we !== 1'b0 || rf_vf !== 1'b0) begin
            errors++;
            $display("FAIL reset_we: we=%b vf=%b required 0 0", rf_we, rf_vf);
        end
        checks++;
        if (rf_a3 !== 5'd0 || rf_wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_wport: a3=%0d wd=%h required 0 0", rf_a3, rf_wd);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy: busy=%h required 0", busy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic_writeback();
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL basic_issue_stall: stall=%b required 0", iss_stall);
        end
        tick();
        iss_valid = 1'b0;
        checks++;
        if (busy !== 32'h0000_0020) begin
            errors++;
            $display("FAIL basic_busy_set: busy=%h required 00000020", busy);
        end
        r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_grant: r0=%b r1=%b required 1 0", r0_ready, r1_ready);
        end
        tick();
        r0_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_vf !== 1'b1 || rf_a3 !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_write: we=%b vf=%b a3=%0d wd=%h required 1 1 5 deadbeef",
                     rf_we, rf_vf, rf_a3, rf_wd);
        end
        checks++;
        if (busy !== 32'h0000_0020) begin
            errors++;
            $display("FAIL basic_busy_hold: busy=%h required 00000020", busy);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_a3 !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_one_cycle: we=%b a3=%0d wd=%h required 0 5 deadbeef",
                     rf_we, rf_a3, rf_wd);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL basic_busy_clear: busy=%h required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        logic [4:0] exp_a [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        exp_a[0] = 5'd3;  exp_a[1] = 5'd4;  exp_a[2] = 5'd3;  exp_a[3] = 5'd4;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'hA0A0A0A0;
        r1_valid = 1'b1; r1_addr = 5'd4; r1_data = 32'hB1B1B1B1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({r1_ready, r0_ready} !== exp_g[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: {r1,r0}=%b required %b", i, {r1_ready, r0_ready},
                         exp_g[i]);
            end
            if (i > 0) begin
                checks++;
                if (rf_we !== 1'b1 || rf_a3 !== exp_a[i-1]) begin
                    errors++;
                    $display("FAIL rr_write%0d: we=%b a3=%0d required 1 %0d", i, rf_we, rf_a3,
                             exp_a[i-1]);
                end
            end
            tick();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd4 || rf_wd !== 32'hB1B1B1B1) begin
            errors++;
            $display("FAIL rr_last_write: we=%b a3=%0d wd=%h required 1 4 b1b1b1b1",
                     rf_we, rf_a3, rf_wd);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL rr_busy_untouched: busy=%h required 0", busy);
        end
        tick();
    endtask

    task automatic test_stall();
        iss_valid = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        tick();
        iss_rd = 5'd9; iss_rs2 = 5'd7;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_raw: stall=%b required 1", iss_stall);
        end
        tick();
        checks++;
        if (busy !== 32'h0000_0080) begin
            errors++;
            $display("FAIL stall_busy_unchanged: busy=%h required 00000080", busy);
        end
        r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'h0000_0077;
        #1;
        checks++;
        if (r1_ready !== 1'b1 || iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_wb_grant: r1_ready=%b stall=%b required 1 1", r1_ready,
                     iss_stall);
        end
        tick();
        r1_valid = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd7 || iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_bypass: we=%b a3=%0d stall=%b required 1 7 1", rf_we, rf_a3,
                     iss_stall);
        end
        tick();
        checks++;
        if (iss_stall !== 1'b0 || busy !== 32'h0) begin
            errors++;
            $display("FAIL stall_release: stall=%b busy=%h required 0 0", iss_stall, busy);
        end
        iss_valid = 1'b0;
        tick();
    endtask

    task automatic test_zero_addr();
        r1_valid = 1'b1; r1_addr = 5'd0; r1_data = 32'h0000_1234;
        #1;
        checks++;
        if (r1_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_grant: r1_ready=%b required 1", r1_ready);
        end
        tick();
        r1_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || rf_vf !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_write: we=%b vf=%b required 0 0", rf_we, rf_vf);
        end
        checks++;
        if (rf_a3 !== 5'd7 || rf_wd !== 32'h0000_0077 || busy !== 32'h0) begin
            errors++;
            $display("FAIL zero_hold: a3=%0d wd=%h busy=%h required 7 00000077 0", rf_a3, rf_wd,
                     busy);
        end
    endtask

    task automatic test_rd_zero();
        iss_valid = 1'b1; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL rd0_stall: stall=%b required 0", iss_stall);
        end
        tick();
        iss_valid = 1'b0;
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("FAIL rd0_busy: busy=%h required 0", busy);
        end
    endtask

    task automatic test_set_wins();
        r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'h0000_0055;
        tick();
        r0_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd5 || iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL setwin_setup: we=%b a3=%0d stall=%b required 1 5 0", rf_we, rf_a3,
                     iss_stall);
        end
        tick();
        iss_valid = 1'b0;
        checks++;
        if (busy !== 32'h0000_0020) begin
            errors++;
            $display("FAIL setwin_busy: busy=%h required 00000020", busy);
        end
    endtask

    task automatic test_reset_midflight();
        iss_valid = 1'b0;
        r0_valid = 1'b1; r0_addr = 5'd6; r0_data = 32'h0000_0066;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_vf !== 1'b0 || busy !== 32'h0) begin
            errors++;
            $display("FAIL midrst_drop: we=%b vf=%b busy=%h required 0 0 0", rf_we, rf_vf, busy);
        end
        @(negedge clk);
        r0_addr = 5'd10; r0_data = 32'h0000_00AA;
        r1_valid = 1'b1; r1_addr = 5'd11; r1_data = 32'h0000_00BB;
        #1;
        checks++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ptr: r0=%b r1=%b required 1 0", r0_ready, r1_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_a3 !== 5'd10 || rf_wd !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL midrst_first: we=%b a3=%0d wd=%h required 1 10 000000aa", rf_we,
                     rf_a3, rf_wd);
        end
        checks++;
        if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_alt: r0=%b r1=%b required 0 1", r0_ready, r1_ready);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_writeback();
        test_round_robin();
        test_stall();
        test_zero_addr();
        test_rd_zero();
        test_set_wins();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
